// File: rtl/segment_burst_gen_pkg.sv
// Shared constants, state encoding and segment-map helper for the segment burst generator.
// Segment map: 64k address space split into NSEG equal segments; addr = {seg, off}.
package segment_burst_gen_pkg;

  localparam int ADDR_W = 16;
  localparam int NSEG   = 8;
  localparam int SEG_W  = $clog2(NSEG);
  localparam int OFF_W  = ADDR_W - SEG_W;
  localparam int LEN_W  = OFF_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Base address of a segment: the segment index sits in the top SEG_W bits.
  function automatic logic [ADDR_W-1:0] seg_base(input logic [SEG_W-1:0] seg);
    seg_base = {seg, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/segment_burst_gen_if.sv
// Request and address-beat handshake bundle between a DMA-style requester and the burst generator.
// slave = burst generator side, master = requester / memory-port side.
interface segment_burst_gen_if
  import segment_burst_gen_pkg::*;
();

  logic             req_valid;
  logic             req_ready;
  logic [SEG_W-1:0] req_seg;
  logic [OFF_W-1:0] req_off;
  logic [LEN_W-1:0] req_len;

  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic              addr_last;
  logic              done;
  logic              err;

  modport slave (
    input  req_valid, req_seg, req_off, req_len, addr_ready,
    output req_ready, addr_valid, addr, addr_last, done, err
  );

  modport master (
    output req_valid, req_seg, req_off, req_len, addr_ready,
    input  req_ready, addr_valid, addr, addr_last, done, err
  );

endinterface

// File: rtl/segment_burst_gen_encode.sv
// segment_encode: combinational {seg, off} -> full address; exact inverse of the segment decoder
// (seg = addr[ADDR_W-1 -: SEG_W], off = remaining low bits).
module segment_encode
  import segment_burst_gen_pkg::*;
(
  input  logic [SEG_W-1:0]  seg,
  input  logic [OFF_W-1:0]  off,
  output logic [ADDR_W-1:0] addr
);

  assign addr = seg_base(seg) | ADDR_W'(off);

endmodule

// File: rtl/segment_burst_gen.sv
// Burst address generator: accepts {segment, start offset, beat count} and emits one address per beat.
// Build option SEG_BURST_GEN_WRAP_EN: offset wraps within the segment instead of truncating the burst.
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a burst request
//   RUN    | presenting beats on addr/addr_valid
//   DONE   | one-cycle done pulse (err with it if the burst was truncated)
module segment_burst_gen
  import segment_burst_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  segment_burst_gen_if.slave bus
);

  state_t           state, state_nx;
  logic [SEG_W-1:0] seg_q, seg_nx;
  logic [OFF_W-1:0] off_q, off_nx;
  logic [LEN_W-1:0] rem_q, rem_nx;
  logic             trunc_q, trunc_nx;
  logic             last_beat;
  logic [ADDR_W-1:0] addr_enc;

`ifdef SEG_BURST_GEN_WRAP_EN
  assign last_beat = (rem_q == LEN_W'(1));
`else
  // The beat at the top of the segment closes the burst; seg never changes mid-burst.
  assign last_beat = (rem_q == LEN_W'(1)) || (&off_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      seg_q   <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state   <= state_nx;
      seg_q   <= seg_nx;
      off_q   <= off_nx;
      rem_q   <= rem_nx;
      trunc_q <= trunc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    seg_nx   = seg_q;
    off_nx   = off_q;
    rem_nx   = rem_q;
    trunc_nx = trunc_q;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          seg_nx   = bus.req_seg;
          off_nx   = bus.req_off;
          rem_nx   = bus.req_len;
          trunc_nx = 1'b0;
          state_nx = (bus.req_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.addr_ready) begin
          off_nx = off_q + OFF_W'(1);
          rem_nx = rem_q - LEN_W'(1);
          if (last_beat) begin
            state_nx = S_DONE;
            // Ending with beats still owed means the segment end cut the burst short.
            trunc_nx = (rem_q != LEN_W'(1));
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  segment_encode u_encode (
    .seg  (seg_q),
    .off  (off_q),
    .addr (addr_enc)
  );

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.addr_valid = (state == S_RUN);
  assign bus.addr       = addr_enc;
  assign bus.addr_last  = (state == S_RUN) && last_beat;
  assign bus.done       = (state == S_DONE);
  assign bus.err        = (state == S_DONE) && trunc_q;

endmodule
